// File: rtl/mgr_pkg.sv
// rtl/mgr_pkg.sv - Shared press codes, display digit codes, write-op encodings and menu states.
package mgr_pkg;

   localparam logic [2:0] P_NXT = 3'b000, P_RLS = 3'b001, P_CON = 3'b010;
   localparam logic [2:0] P_DEL = 3'b011, P_RIS = 3'b100, P_NONE = 3'b111;

   localparam logic [4:0] D_0 = 5'd0, D_1 = 5'd1, D_2 = 5'd2, D_3 = 5'd3, D_4 = 5'd4;
   localparam logic [4:0] D_5 = 5'd5, D_6 = 5'd6, D_7 = 5'd7, D_8 = 5'd8, D_9 = 5'd9;
   localparam logic [4:0] L_A = 5'd10, L_B = 5'd11, L_C = 5'd12, L_D = 5'd13, L_E = 5'd14;
   localparam logic [4:0] L_F = 5'd15, L_H = 5'd16, L_I = 5'd17, L_J = 5'd18, L_L = 5'd19;
   localparam logic [4:0] L_N = 5'd20, L_O = 5'd21, L_P = 5'd22, L_R = 5'd23, L_S = 5'd24;
   localparam logic [4:0] L_T = 5'd25, L_U = 5'd26, L_V = 5'd27, L_Y = 5'd28;
   localparam logic [4:0] D_DASH = 5'd29, L_G = 5'd30, D_BLANK = 5'd31;

   localparam logic [1:0] WR_OP_NONE = 2'b00, WR_OP_REV = 2'b01, WR_OP_SET = 2'b11;

   typedef enum logic [2:0] {
      S_MENU, S_SEL_SET, S_SET_OFF, S_SEL_REV, S_WAIT, S_DONE, S_ERR
   } state_e;

endpackage

// File: rtl/manager_vip_cfg_if.sv
// rtl/manager_vip_cfg_if.sv - VIP RAM write/readback port between the submenu and the RAM.
interface manager_vip_cfg_if #(
   parameter int OFF_W = 5
) ();
   logic             wr_req;
   logic [1:0]       wr_op;
   logic [OFF_W-1:0] wr_off;
   logic             wr_ack;
   logic [OFF_W-1:0] cur_off_i;

   modport master (output wr_req, wr_op, wr_off, input wr_ack, cur_off_i);
   modport slave  (input wr_req, wr_op, wr_off, output wr_ack, cur_off_i);
endinterface

// File: rtl/mgr_cyc_timer.sv
// rtl/mgr_cyc_timer.sv - Down-counter loaded with CYC-1; expired while the count sits at zero.
module mgr_cyc_timer #(
   parameter int CYC = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic load,
   input  logic dec,
   output logic expired
);
   localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(CYC - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                        cnt_d = '0;
      else if (load)                  cnt_d = LOAD_VAL;
      else if (dec && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);
endmodule

// File: rtl/manager_vip_cfg.sv
// rtl/manager_vip_cfg.sv - VIP tier manager submenu with RAM write handshake.
// MGR_VIP_TIMEOUT_EN adds an ack timeout that lands in the ERR screen.
module manager_vip_cfg
   import mgr_pkg::*;
#(
   parameter int SW_W     = 8,
   parameter int OFF_W    = 5,
   parameter int N_LVL    = 9,
   parameter int DONE_CYC = 50_000_000,
   parameter int TMO_CYC  = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [2:0]        press,
   input  logic [SW_W-1:0]   switch,
   manager_vip_cfg_if.master ram,
   output logic              rls_req,
   output logic [29:0]       show,
   output logic [7:0]        led
);
   localparam logic [SW_W-1:0] N_LVL_SW = SW_W'(N_LVL);

   if (N_LVL >= 2**OFF_W || N_LVL > 99 || DONE_CYC < 1 || TMO_CYC < 1) begin : g_cfg_check
      $error("manager_vip_cfg: illegal parameter set");
   end

   state_e           state_q, state_d;
   logic [1:0]       wr_op_q, wr_op_d;
   logic [OFF_W-1:0] wr_off_q, wr_off_d;
   logic             rls_req_q, rls_req_d;
   logic             act_q, act_d;
   logic             done_exp, err_bit;
   logic             sw_legal;

   assign sw_legal = (switch != '0) && (switch <= N_LVL_SW);

`ifdef MGR_VIP_TIMEOUT_EN
   logic err_q, err_d, tmo_exp;

   mgr_cyc_timer #(.CYC(TMO_CYC)) u_tmo_tmr (
      .clk(clk), .rst_n(rst_n), .clr(!en),
      .load(state_d == S_WAIT && state_q != S_WAIT),
      .dec(state_q == S_WAIT), .expired(tmo_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign err_bit = err_q;
`else
   assign err_bit = 1'b0;
`endif

   mgr_cyc_timer #(.CYC(DONE_CYC)) u_done_tmr (
      .clk(clk), .rst_n(rst_n), .clr(!en),
      .load(state_d == S_DONE && state_q != S_DONE),
      .dec(state_q == S_DONE), .expired(done_exp)
   );

   always_comb begin
      state_d   = state_q;
      wr_op_d   = wr_op_q;
      wr_off_d  = wr_off_q;
      rls_req_d = 1'b0;
      act_d     = 1'b1;
`ifdef MGR_VIP_TIMEOUT_EN
      err_d     = err_q;
`endif
      if (!en) begin
         state_d  = S_MENU;
         wr_op_d  = WR_OP_NONE;
         wr_off_d = '0;
         act_d    = 1'b0;
`ifdef MGR_VIP_TIMEOUT_EN
         err_d    = 1'b0;
`endif
      end else begin
         case (state_q)
            S_MENU: begin
               if (press == P_CON && switch == SW_W'(1))      state_d = S_SEL_SET;
               else if (press == P_CON && switch == SW_W'(2)) state_d = S_SEL_REV;
               else if (press == P_RLS)                       rls_req_d = 1'b1;
            end
            S_SEL_SET: begin
               if (press == P_CON)                         state_d = S_SET_OFF;
               else if (press == P_RLS || press == P_RIS)  state_d = S_MENU;
            end
            S_SET_OFF: begin
               if (press == P_CON && sw_legal) begin
                  wr_off_d = switch[OFF_W-1:0];
                  wr_op_d  = WR_OP_SET;
                  state_d  = S_WAIT;
               end else if (press == P_RLS) state_d = S_SEL_SET;
               else if (press == P_RIS)     state_d = S_MENU;
            end
            S_SEL_REV: begin
               if (press == P_CON) begin
                  wr_off_d = '0;
                  wr_op_d  = WR_OP_REV;
                  state_d  = S_WAIT;
               end else if (press == P_RLS || press == P_RIS) state_d = S_MENU;
            end
            S_WAIT: begin
               if (ram.wr_ack) state_d = S_DONE;
`ifdef MGR_VIP_TIMEOUT_EN
               else if (tmo_exp) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
`endif
            end
            S_DONE: begin
               if (press == P_CON || done_exp) state_d = S_MENU;
            end
`ifdef MGR_VIP_TIMEOUT_EN
            S_ERR: begin
               if (press == P_CON || press == P_RLS) begin
                  state_d = S_MENU;
                  err_d   = 1'b0;
               end
            end
`endif
            default: state_d = S_MENU;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_MENU;
         wr_op_q   <= WR_OP_NONE;
         wr_off_q  <= '0;
         rls_req_q <= 1'b0;
         act_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_op_q   <= wr_op_d;
         wr_off_q  <= wr_off_d;
         rls_req_q <= rls_req_d;
         act_q     <= act_d;
      end
   end

   assign ram.wr_req = (state_q == S_WAIT);
   assign ram.wr_op  = wr_op_q;
   assign ram.wr_off = wr_off_q;
   assign rls_req    = rls_req_q;
   assign led        = {err_bit, state_q == S_DONE, state_q == S_WAIT, 5'(wr_off_q)};

   // Screen stays blank until the first enabled edge after reset or re-enable.
   logic [3:0]  tens, ones;
   logic [4:0]  tens_code;
   logic [29:0] disp;

   assign ones      = 4'(ram.cur_off_i % 10);
   assign tens      = 4'((ram.cur_off_i / 10) % 10);
   assign tens_code = (tens == 4'd0) ? D_BLANK : {1'b0, tens};

   always_comb begin
      disp = {6{D_BLANK}};
      case (state_q)
         S_MENU:    disp = {D_BLANK, D_BLANK, D_BLANK, L_V, L_I, L_P};
         S_SEL_SET: disp = {D_BLANK, L_O, L_F, L_F, tens_code, {1'b0, ones}};
         S_SET_OFF: disp = {L_O, L_F, L_F, D_BLANK, L_I, L_N};
         S_SEL_REV: disp = {L_R, L_E, L_V, L_I, L_P, D_DASH};
         S_WAIT:    disp = {6{D_DASH}};
         S_DONE:    disp = {D_BLANK, D_BLANK, L_D, L_O, L_N, L_E};
         S_ERR:     disp = {D_BLANK, D_BLANK, D_BLANK, L_E, L_R, L_R};
         default:   disp = {6{D_BLANK}};
      endcase
   end

   assign show = act_q ? disp : {6{D_BLANK}};
endmodule

// File: tb/tb_manager_vip_cfg.sv
// tb/tb_manager_vip_cfg.sv - Self-checking bench for manager_vip_cfg against a screen-level model.
module tb_manager_vip_cfg;
   localparam int SW_W = 8, OFF_W = 5, N_LVL = 9, DONE_CYC = 10, TMO_CYC = 20;
   localparam logic [2:0] NXT = 3'b000, RLS = 3'b001, CON = 3'b010;
   localparam logic [2:0] DEL = 3'b011, RIS = 3'b100, NONE = 3'b111;

   logic              clk = 1'b0;
   logic              rst_n, en;
   logic [2:0]        press;
   logic [SW_W-1:0]   switch;
   logic              rls_req;
   logic [29:0]       show;
   logic [7:0]        led;

   manager_vip_cfg_if #(.OFF_W(OFF_W)) ram ();

   manager_vip_cfg #(
      .SW_W(SW_W), .OFF_W(OFF_W), .N_LVL(N_LVL), .DONE_CYC(DONE_CYC), .TMO_CYC(TMO_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .press(press), .switch(switch),
      .ram(ram), .rls_req(rls_req), .show(show), .led(led)
   );

   always #5 clk = ~clk;

   int               checks = 0, errors = 0;
   string            scr;
   logic [OFF_W-1:0] last_off;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] enc(string s);
      string       letters = "abcdefhijlnoprstuvy";
      logic [29:0] r = '0;
      byte         c;
      int          code;
      for (int i = 0; i < 6; i++) begin
         c = s[i];
         if (c >= "A" && c <= "Z") c = c + 8'd32;
         code = 31;
         if (c == "-") code = 29;
         else if (c == "g") code = 30;
         else if (c >= "0" && c <= "9") code = c - "0";
         else for (int k = 0; k < letters.len(); k++) if (letters[k] == c) code = 10 + k;
         r[29-5*i -: 5] = code[4:0];
      end
      return r;
   endfunction

   function automatic string text_of(string st, int cur);
      if (st == "MENU")    return "   vIP";
      if (st == "SEL_SET") begin
         if ((cur / 10) % 10 == 0) return $sformatf(" oFF %0d", cur % 10);
         return $sformatf(" oFF%0d%0d", (cur / 10) % 10, cur % 10);
      end
      if (st == "SET_OFF") return "oFF in";
      if (st == "SEL_REV") return "rEvIP-";
      if (st == "WAIT")    return "------";
      if (st == "DONE")    return "  donE";
      if (st == "ERR")     return "   Err";
      return "      ";
   endfunction

   function automatic logic [7:0] exp_led(bit req, bit done, bit err);
      return {err, done, req, 5'(last_off)};
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic push(logic [2:0] p, logic [SW_W-1:0] sw);
      press = p; switch = sw;
      @(negedge clk);
      press = NONE;
   endtask

   task automatic chk_scr(string tag);
      chk(tag, show, enc(text_of(scr, int'(ram.cur_off_i))));
   endtask

   task automatic do_write(int delay, logic [1:0] op, logic [OFF_W-1:0] off);
      int n = 0;
      chk("req_rise", ram.wr_req, 1);
      while (ram.wr_req === 1'b1 && n < 200) begin
         n++;
         chk("wr_op", ram.wr_op, op);
         chk("wr_off", ram.wr_off, off);
         if (n == delay + 1) ram.wr_ack = 1'b1;
         cyc();
         ram.wr_ack = 1'b0;
      end
      chk("req_len", n, delay + 1);
      last_off = off;
      scr = "DONE";
      chk_scr("done_scr");
      chk("done_led", led, exp_led(0, 1, 0));
   endtask

   task automatic done_hold();
      int m = 0;
      while (show === enc("  donE") && m < 100) begin m++; cyc(); end
      chk("done_len", m, DONE_CYC);
      scr = "MENU";
      chk_scr("after_done");
   endtask

   logic [2:0] codes [6] = '{NXT, RLS, CON, DEL, RIS, NONE};

   initial begin
      logic [2:0]      p;
      logic [SW_W-1:0] sw;
      string           nscr;
      bit              exp_rls, wr;
      logic [1:0]      wop;
      logic [OFF_W-1:0] woff;
      int              n, v;

      rst_n = 1'b0; en = 1'b0; press = NONE; switch = '0;
      ram.wr_ack = 1'b0; ram.cur_off_i = '0; last_off = '0;
      cyc(); cyc();
      chk("rst_show", show, 30'h3FFFFFFF);
      chk("rst_req", ram.wr_req, 0);
      chk("rst_op", ram.wr_op, 0);
      chk("rst_off", ram.wr_off, 0);
      chk("rst_led", led, 0);
      chk("rst_rls", rls_req, 0);
      rst_n = 1'b1; en = 1'b1;
      cyc();
      scr = "MENU"; chk_scr("menu0");

      // Set path with switch 5, ack after three request cycles.
      ram.cur_off_i = 5'($urandom_range(0, 31));
      push(CON, 1); scr = "SEL_SET"; chk_scr("sel_set");
      push(CON, 0); scr = "SET_OFF"; chk_scr("set_off");
      push(CON, 5);
      do_write(3, 2'b11, 5);
      done_hold();
      ram.wr_ack = 1'b1; cyc(); ram.wr_ack = 1'b0;
      chk("stray_ack_req", ram.wr_req, 0);
      chk_scr("stray_ack_scr");

      // Illegal tier values are ignored in SET_OFF.
      push(CON, 1); push(CON, 0);
      foreach (codes[i]) begin end
      for (int i = 0; i < 4; i++) begin
         sw = (i == 0) ? 8'd0 : (i == 1) ? 8'd10 : (i == 2) ? 8'hFF : 8'($urandom_range(10, 254));
         push(CON, sw);
         chk("illegal_req", ram.wr_req, 0);
         scr = "SET_OFF"; chk_scr("illegal_scr");
      end
      push(CON, 9);
      do_write($urandom_range(0, 5), 2'b11, 9);
      push(CON, 0); scr = "MENU"; chk_scr("done_con_exit");

      // Revoke path, ack on the first request cycle.
      push(CON, 2); scr = "SEL_REV"; chk_scr("sel_rev");
      push(CON, 8'($urandom));
      do_write(0, 2'b01, 0);
      done_hold();

      // Navigation and release request.
      push(RLS, 0);
      chk("rls_pulse", rls_req, 1);
      cyc();
      chk("rls_one", rls_req, 0);
      push(CON, 1); scr = "SEL_SET";
      ram.cur_off_i = 5'd7;  #1 chk_scr("off_7");
      ram.cur_off_i = 5'd23; #1 chk_scr("off_23");
      push(CON, 0); push(RLS, 0); scr = "SEL_SET"; chk_scr("set_rls");
      push(CON, 0); push(RIS, 0); scr = "MENU"; chk_scr("set_ris");

      // en dropped in WAIT abandons the request.
      push(CON, 2); push(CON, 0);
      chk("wait_req", ram.wr_req, 1);
      en = 1'b0; cyc();
      chk("en_req", ram.wr_req, 0);
      chk("en_show", show, 30'h3FFFFFFF);
      chk("en_led", led, 0);
      chk("en_op", ram.wr_op, 0);
      en = 1'b1; cyc(); last_off = '0; scr = "MENU"; chk_scr("en_back");

      // Asynchronous reset in the middle of DONE.
      push(CON, 1); push(CON, 0); push(CON, 3);
      do_write(1, 2'b11, 3);
      cyc(); cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_show", show, 30'h3FFFFFFF);
      chk("arst_led", led, 0);
      chk("arst_req", ram.wr_req, 0);
      chk("arst_op", ram.wr_op, 0);
      chk("arst_off", ram.wr_off, 0);
      cyc(); rst_n = 1'b1; cyc();
      last_off = '0; scr = "MENU"; chk_scr("arst_menu");

      // Unacknowledged request.
      v = $urandom_range(1, N_LVL);
      push(CON, 1); push(CON, 0); push(CON, 8'(v));
      n = 0;
`ifdef MGR_VIP_TIMEOUT_EN
      while (ram.wr_req === 1'b1 && n < 200) begin n++; cyc(); end
      chk("tmo_len", n, TMO_CYC);
      last_off = 5'(v);
      scr = "ERR"; chk_scr("err_scr");
      chk("err_led", led, exp_led(0, 0, 1));
      push(CON, 0); scr = "MENU"; chk_scr("err_exit");
      chk("err_clr", led, exp_led(0, 0, 0));
`else
      while (ram.wr_req === 1'b1 && n < 1000) begin n++; cyc(); end
      chk("no_tmo_len", n, 1000);
      en = 1'b0; cyc(); en = 1'b1; cyc();
      last_off = '0; scr = "MENU"; chk_scr("no_tmo_exit");
`endif

      // Random press walk against the screen model.
      for (int it = 0; it < 60; it++) begin
         p  = codes[$urandom_range(0, 5)];
         sw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11));
         ram.cur_off_i = 5'($urandom_range(0, 31));
         nscr = scr; exp_rls = 0; wr = 0; wop = 2'b00; woff = '0;
         if (scr == "MENU") begin
            if (p == CON && sw == 1)      nscr = "SEL_SET";
            else if (p == CON && sw == 2) nscr = "SEL_REV";
            else if (p == RLS)            exp_rls = 1;
         end else if (scr == "SEL_SET") begin
            if (p == CON)                    nscr = "SET_OFF";
            else if (p == RLS || p == RIS)   nscr = "MENU";
         end else if (scr == "SET_OFF") begin
            if (p == CON && sw >= 1 && sw <= N_LVL) begin wr = 1; wop = 2'b11; woff = 5'(sw); end
            else if (p == RLS) nscr = "SEL_SET";
            else if (p == RIS) nscr = "MENU";
         end else if (scr == "SEL_REV") begin
            if (p == CON)                    begin wr = 1; wop = 2'b01; woff = '0; end
            else if (p == RLS || p == RIS)   nscr = "MENU";
         end
         push(p, sw);
         chk("rnd_rls", rls_req, exp_rls);
         if (wr) begin
            do_write($urandom_range(0, 6), wop, woff);
            if ($urandom_range(0, 1) == 1) begin
               push(CON, 0); scr = "MENU"; chk_scr("rnd_con_exit");
            end else done_hold();
         end else begin
            scr = nscr;
            chk_scr("rnd_scr");
            chk("rnd_led", led, exp_led(0, 0, 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
